pcm_sample_fifo: RTL

Buffers 16-bit PCM samples from the PDM microphone front end (pdm_mic pcm_sample/pcm_valid) so the LiteX CPU can drain them in bursts through CSRs instead of once per sample.
- Single-clock synchronous FIFO with fill level, programmable level-threshold interrupt and sticky overflow flag.
- Sits between the PDM/CIC stage and the CSR bank.

---
 rtl/pcm_sample_fifo.sv | 191 +++++++++++++++++++
 1 files changed

// File: rtl/pcm_sample_fifo.sv
// pcm_sample_fifo
//   Single-clock FIFO buffering 16-bit PCM samples from the PDM/CIC stage so
//   the CPU can drain them in bursts through CSRs. Provides a fill level, a
//   sticky level-threshold interrupt and a sticky overflow flag.
//
//   Optional feature (macro PCM_SAMPLE_FIFO_DCBLOCK_EN): a DC-blocking
//   high-pass filter in front of the write port, adding one cycle of write
//   latency. With the macro undefined, samples are stored bit-exact.
//
// Ports
//   clk            system clock
//   rst            synchronous reset, active-high
//   enable         capture enable; writes ignored when low
//   in_sample      signed PCM sample from the mic stage
//   in_valid       single-cycle strobe qualifying in_sample
//   flush          pulse; empties the FIFO (priority over write and pop)
//   rd_en          pop strobe
//   rd_data        popped sample (registered, latency 1)
//   rd_valid       one-cycle pulse when rd_data updates
//   level          samples currently stored, 0..DEPTH
//   threshold      irq level; 0 disables irq
//   irq            level-threshold interrupt, sticky
//   irq_clear      pulse; clears irq (wins over a same-cycle set)
//   overflow       sticky; a sample was dropped
//   overflow_clear pulse; clears overflow (loses to a same-cycle drop)
module pcm_sample_fifo #(
    parameter int DEPTH_LOG2 = 8,
    parameter int DCB_SHIFT  = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  enable,
    input  logic [15:0]           in_sample,
    input  logic                  in_valid,
    input  logic                  flush,
    input  logic                  rd_en,
    output logic [15:0]           rd_data,
    output logic                  rd_valid,
    output logic [DEPTH_LOG2:0]   level,
    input  logic [DEPTH_LOG2:0]   threshold,
    output logic                  irq,
    input  logic                  irq_clear,
    output logic                  overflow,
    input  logic                  overflow_clear
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] FULL_LEVEL = (DEPTH_LOG2 + 1)'(DEPTH);

    if (DEPTH_LOG2 < 2 || DEPTH_LOG2 > 12) begin : g_bad_depth
        $error("pcm_sample_fifo: DEPTH_LOG2 out of range 2..12");
    end
    if (DCB_SHIFT < 1 || DCB_SHIFT > 23) begin : g_bad_shift
        $error("pcm_sample_fifo: DCB_SHIFT out of range 1..23");
    end

    logic [15:0]           mem [DEPTH];
    logic [DEPTH_LOG2-1:0] wptr;
    logic [DEPTH_LOG2-1:0] rptr;

    // Write-port request, either straight from the input or from the filter.
    logic                  wr_valid;
    logic [15:0]           wr_data;

`ifdef PCM_SAMPLE_FIFO_DCBLOCK_EN
    logic signed [15:0] x_prev;
    logic signed [15:0] x_cur;
    logic signed [23:0] x_ext;
    logic signed [23:0] xp_ext;
    logic signed [23:0] y_state;
    logic signed [23:0] y_shr;
    logic signed [23:0] y_next;
    logic [15:0]        y_sat;
    logic               accept_in;

    assign accept_in = in_valid & enable;

    // All operands kept signed so the >>> stays arithmetic.
    always_comb begin
        x_cur  = in_sample;
        x_ext  = 24'(x_cur);
        xp_ext = 24'(x_prev);
        y_shr  = y_state >>> DCB_SHIFT;
        y_next = x_ext - xp_ext + y_state - y_shr;
        if (y_next > 24'sd32767) begin
            y_sat = 16'h7FFF;
        end else if (y_next < -24'sd32768) begin
            y_sat = 16'h8000;
        end else begin
            y_sat = y_next[15:0];
        end
    end

    // Filter state advances on every accepted input, even if the FIFO is
    // full and the sample is later dropped; flush leaves it untouched.
    always_ff @(posedge clk) begin
        if (rst) begin
            x_prev   <= '0;
            y_state  <= '0;
            wr_valid <= 1'b0;
            wr_data  <= '0;
        end else begin
            wr_valid <= accept_in;
            if (accept_in) begin
                x_prev  <= x_cur;
                y_state <= y_next;
                wr_data <= y_sat;
            end
        end
    end
`else
    assign wr_valid = in_valid & enable;
    assign wr_data  = in_sample;
`endif

    logic empty;
    logic full;
    logic do_pop;
    logic do_push;
    logic drop;
    logic irq_cond;

    assign empty    = (level == '0);
    assign full     = (level == FULL_LEVEL);
    assign do_pop   = rd_en & ~empty & ~flush;
    // At full a same-cycle pop frees the slot, so the write still lands.
    assign do_push  = wr_valid & ~flush & (~full | do_pop);
    assign drop     = wr_valid & ~flush & full & ~do_pop;
    assign irq_cond = (threshold != '0) && (level >= threshold);

    // Storage array kept free of reset so it maps onto block RAM.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wptr] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_data  <= '0;
            rd_valid <= 1'b0;
        end else begin
            rd_valid <= do_pop;
            if (do_pop) begin
                rd_data <= mem[rptr];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr  <= '0;
            rptr  <= '0;
            level <= '0;
        end else if (flush) begin
            rptr  <= wptr;
            level <= '0;
        end else begin
            if (do_push) begin
                wptr <= wptr + 1'b1;
            end
            if (do_pop) begin
                rptr <= rptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            irq      <= 1'b0;
            overflow <= 1'b0;
        end else begin
            if (irq_clear) begin
                irq <= 1'b0;
            end else if (irq_cond) begin
                irq <= 1'b1;
            end
            if (drop) begin
                overflow <= 1'b1;
            end else if (overflow_clear) begin
                overflow <= 1'b0;
            end
        end
    end

endmodule
